// File: rtl/cc_display_scan.sv
// cc_display_scan: multiplexed 6-digit seven-segment driver for the CC clock core.
// One digit is lit per SCAN_DIV-cycle slot. All digits plus the alarm flag and the
// blink phase are captured once per frame, so one frame never shows two different times.
module cc_display_scan #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8,
    parameter int COMMON_ANODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       H1,
    input  logic [3:0] H2,
    input  logic [2:0] M1,
    input  logic [3:0] M2,
    input  logic [2:0] S1,
    input  logic [3:0] S2,
    input  logic       led_alarm,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic          INV        = (COMMON_ANODE != 0);

    // Everything one frame needs. phase is the blink phase in force for that frame.
    typedef struct packed {
        logic       h1;
        logic [3:0] h2;
        logic [2:0] m1;
        logic [3:0] m2;
        logic [2:0] s1;
        logic [3:0] s2;
        logic       alarm;
        logic       phase;
    } snap_t;

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    snap_t         snap_q, snap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;
    logic          frame_start_q, frame_start_d;

    logic          load;
    snap_t         cur;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;  // non-BCD shows a dash
        endcase
    endfunction

    // Scan timing, frame snapshot and blink phase bookkeeping.
    always_comb begin
        load          = (pre_q == '0) && (idx_q == 3'd0);
        pre_d         = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        idx_d         = idx_q;
        if (pre_q == PRE_LAST)
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

        snap_d        = snap_q;
        if (load)
            snap_d = '{h1: H1, h2: H2, m1: M1, m2: M2, s1: S1, s2: S2,
                       alarm: led_alarm, phase: phase_q};
        // In the load cycle snap_d already holds the live inputs, so slot 0 of a new
        // frame shows new data without waiting a cycle for the snapshot register.
        cur           = snap_d;

        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        if (load) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        frame_start_d = load;
    end

    // Digit select, decode and blanking for the slot currently selected.
    always_comb begin
        case (idx_q)
            3'd0:    digit = {3'b000, cur.h1};
            3'd1:    digit = cur.h2;
            3'd2:    digit = {1'b0, cur.m1};
            3'd3:    digit = cur.m2;
            3'd4:    digit = {1'b0, cur.s1};
            default: digit = cur.s2;
        endcase

        blank = (cur.alarm && cur.phase) ||
                ((idx_q == 3'd0) && blank_lz && !cur.h1);

        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (!blank) begin
            an_d  = 6'b000001 << idx_q;
            seg_d = seg_decode(digit);
            dp_d  = (idx_q == 3'd1) || (idx_q == 3'd3);
        end
    end

    // State and output registers; outputs are held in active-high form.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q         <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            an_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Polarity applied last so reset leaves the pins at their inactive level.
    assign seg         = seg_q ^ {7{INV}};
    assign dp          = dp_q ^ INV;
    assign an          = an_q ^ {6{INV}};
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_cc_display_scan.sv
// Scoreboard bench for cc_display_scan: an active-high and a common-anode instance
// share stimulus; expected per-cycle outputs are queued by the stimulus and popped
// by an independent monitor one delta after each rising edge.
module tb_cc_display_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       H1;
    logic [3:0] H2;
    logic [2:0] M1;
    logic [3:0] M2;
    logic [2:0] S1;
    logic [3:0] S2;
    logic       led_alarm;
    logic       blank_lz;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [5:0] an0, an1;
    logic       fs0, fs1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];

    localparam logic [0:5][6:0] BASE  = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
    localparam logic [0:5][6:0] M2_9  = {7'h06, 7'h5B, 7'h4F, 7'h6F, 7'h6D, 7'h7D};
    localparam logic [0:5][6:0] H1_0  = {7'h3F, 7'h5B, 7'h4F, 7'h6F, 7'h6D, 7'h7D};
    localparam logic [0:5][6:0] H2_12 = {7'h06, 7'h40, 7'h4F, 7'h6F, 7'h6D, 7'h7D};

    cc_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .COMMON_ANODE(0)) dut0 (
        .clk(clk), .reset(reset), .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
        .led_alarm(led_alarm), .blank_lz(blank_lz),
        .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0));

    cc_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .COMMON_ANODE(1)) dut1 (
        .clk(clk), .reset(reset), .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
        .led_alarm(led_alarm), .blank_lz(blank_lz),
        .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1));

    always #5 clk = ~clk;

    // Monitor: one queued expectation per rising edge, checked on both polarities.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({an0, seg0, dp0, fs0} !== {e.an, e.seg, e.dp, e.fs}) begin
                    n_err++;
                    $display("FAIL scan_ca0 t=%0t: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                             $time, an0, seg0, dp0, fs0, e.an, e.seg, e.dp, e.fs);
                end
                n_cmp++;
                if ({an1, seg1, dp1, fs1} !== {~e.an, ~e.seg, ~e.dp, e.fs}) begin
                    n_err++;
                    $display("FAIL scan_ca1 t=%0t: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                             $time, an1, seg1, dp1, fs1, ~e.an, ~e.seg, ~e.dp, e.fs);
                end
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Both instances must sit at their inactive levels while reset is asserted.
    task automatic chk_rst(input string nm);
        n_cmp++;
        if ({an0, seg0, dp0, fs0} !== {6'h00, 7'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL %s_ca0: got an=%b seg=%h dp=%b fs=%b, want all 0", nm, an0, seg0, dp0, fs0);
        end
        n_cmp++;
        if ({an1, seg1, dp1, fs1} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL %s_ca1: got an=%b seg=%h dp=%b fs=%b, want an=111111 seg=7f dp=1 fs=0",
                     nm, an1, seg1, dp1, fs1);
        end
    endtask

    // Drive one frame (or its first ncyc cycles), queuing the expected output after each
    // edge. Entered just after a falling edge whose following rising edge is the load cycle.
    // chg_kind 0 changes M2, 1 changes led_alarm, before rising edge number chg_at.
    task automatic run_frame(input logic [0:5][6:0] segs, input logic [5:0] blank,
                             input int ncyc, input int chg_at, input int chg_kind,
                             input logic [3:0] chg_val);
        for (int c = 0; c < ncyc; c++) begin
            exp_t e;
            int   k;
            if (c == chg_at) begin
                if (chg_kind == 0) M2 = chg_val;
                else               led_alarm = chg_val[0];
            end
            k     = c / 4;
            e.an  = blank[k] ? 6'b000000 : (6'b000001 << k);
            e.seg = blank[k] ? 7'h00 : segs[k];
            e.dp  = !blank[k] && (k == 1 || k == 3);
            e.fs  = (c == 0);
            q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        H1 = 1'b1; H2 = 4'd2; M1 = 3'd3; M2 = 4'd4; S1 = 3'd5; S2 = 4'd6;
        led_alarm = 1'b0;
        blank_lz  = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst("reset_init");
        reset = 1'b0;

        // F1 basic scan; F2 M2 changes during slot 2 but is not seen; F3 shows it.
        run_frame(BASE, 6'b000000, 24, -1, 0, 4'd0);
        run_frame(BASE, 6'b000000, 24,  9, 0, 4'd9);
        run_frame(M2_9, 6'b000000, 24, -1, 0, 4'd0);

        // F4 leading-zero blank; F5 same digit shown as 0 when blanking is off.
        H1 = 1'b0; blank_lz = 1'b1;
        run_frame(M2_9, 6'b000001, 24, -1, 0, 4'd0);
        blank_lz = 1'b0;
        run_frame(H1_0, 6'b000000, 24, -1, 0, 4'd0);

        // F6 non-BCD hours digit shows a dash, colon still on.
        H1 = 1'b1; H2 = 4'd12;
        run_frame(H2_12, 6'b000000, 24, -1, 0, 4'd0);

        // Blink with two frames per half-period: frames 7,8 fall in phase 1 (dark),
        // 9,10 in phase 0 (lit), 11 dark; alarm dropped mid-11 so 12 is lit.
        H2 = 4'd2; led_alarm = 1'b1;
        run_frame(M2_9, 6'b111111, 24, -1, 0, 4'd0);
        run_frame(M2_9, 6'b111111, 24, -1, 0, 4'd0);
        run_frame(M2_9, 6'b000000, 24, -1, 0, 4'd0);
        run_frame(M2_9, 6'b000000, 24, -1, 0, 4'd0);
        run_frame(M2_9, 6'b111111, 24,  5, 1, 4'd0);
        run_frame(M2_9, 6'b000000, 24, -1, 0, 4'd0);

        // Reset during slot 4 clears outputs without a clock edge, then scan restarts.
        run_frame(M2_9, 6'b000000, 18, -1, 0, 4'd0);
        reset = 1'b1;
        #1;
        chk_rst("reset_async");
        repeat (3) @(negedge clk);
        chk_rst("reset_hold");
        reset = 1'b0;
        run_frame(M2_9, 6'b000000, 24, -1, 0, 4'd0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
